hazard_unit: RTL and testbench

Pipeline control block for the 5-stage RISC-V core. It generates the 2-bit forwarding selects consumed by the E-stage `mux3` operand selectors, plus the stall and flush controls for the pipeline registers. It detects load-use hazards, taken-branch flushes and data-memory wait states. The forwarding selects are computed one stage early, from D-stage sources, and registered on pipeline advance, so the E-stage muxes see glitch-free selects from a flop. The block also keeps stall and flush performance counters and a sticky memory-timeout flag.

---
 rtl/hazard_unit.sv | 145 ++++++++++++++
 tb/tb_hazard_unit.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// Pipeline hazard control for the 5-stage RISC-V core: forwarding selects,
// stall/flush controls, performance counters and a sticky memory-timeout flag.
module hazard_unit #(
  parameter int CNT_WIDTH   = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [4:0]           Rs1D,
  input  logic [4:0]           Rs2D,
  input  logic [4:0]           RdE,
  input  logic [4:0]           RdM,
  input  logic                 RegWriteE,
  input  logic                 RegWriteM,
  input  logic                 ResultSrcE0,
  input  logic                 PCSrcE,
  input  logic                 MemReqM,
  input  logic                 MemReadyM,
  output logic [1:0]           ForwardAE,
  output logic [1:0]           ForwardBE,
  output logic                 StallF,
  output logic                 StallD,
  output logic                 StallE,
  output logic                 StallM,
  output logic                 FlushD,
  output logic                 FlushE,
  output logic                 FlushW,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt,
  output logic                 mem_err
);

  localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(MEM_TIMEOUT);

  typedef enum logic {S_RUN, S_WAIT} state_t;

  state_t                state_q, state_d;
  logic [WCNT_W-1:0]     wait_q, wait_d;
  logic                  err_q, err_d;
  logic [1:0]            fwd_a_q, fwd_a_d;
  logic [1:0]            fwd_b_q, fwd_b_d;
  logic [CNT_WIDTH-1:0]  stall_q, stall_d;
  logic [CNT_WIDTH-1:0]  flush_q, flush_d;
  logic                  ld_use;
  logic                  mem_wait;

  // Youngest producer wins: the E-stage writer moves to M, the M-stage writer to W.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src, input logic [4:0] rd_e,
                                         input logic we_e, input logic [4:0] rd_m,
                                         input logic we_m);
    if (we_e && rd_e != 5'd0 && rd_e == src)      return 2'b10;
    else if (we_m && rd_m != 5'd0 && rd_m == src) return 2'b01;
    else                                          return 2'b00;
  endfunction

  assign ld_use   = ResultSrcE0 & (RdE != 5'd0) & ((RdE == Rs1D) | (RdE == Rs2D));
  assign mem_wait = MemReqM & ~MemReadyM;

  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (mem_wait) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (PCSrcE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (ld_use) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  always_comb begin
    fwd_a_d = fwd_a_q;
    fwd_b_d = fwd_b_q;
    if (!mem_wait) begin
      if (FlushE) begin
        fwd_a_d = 2'b00;
        fwd_b_d = 2'b00;
      end else begin
        fwd_a_d = fwd_sel(Rs1D, RdE, RegWriteE, RdM, RegWriteM);
        fwd_b_d = fwd_sel(Rs2D, RdE, RegWriteE, RdM, RegWriteM);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    unique case (state_q)
      S_RUN: begin
        if (mem_wait) begin
          state_d = S_WAIT;
          wait_d  = WCNT_W'(1);
        end
      end
      S_WAIT: begin
        if (MemReadyM) state_d = S_RUN;
        if (mem_wait)  wait_d  = (wait_q == WCNT_MAX) ? wait_q : wait_q + 1'b1;
      end
      default: state_d = S_RUN;
    endcase
    err_d   = err_q | (wait_d == WCNT_MAX);
    stall_d = stall_q + CNT_WIDTH'(StallF);
    flush_d = flush_q + CNT_WIDTH'(PCSrcE & ~mem_wait);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RUN;
      wait_q  <= '0;
      err_q   <= 1'b0;
      fwd_a_q <= 2'b00;
      fwd_b_q <= 2'b00;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign ForwardAE = fwd_a_q;
  assign ForwardBE = fwd_b_q;
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
  assign mem_err   = err_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit.
module tb_hazard_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  Rs1D, Rs2D, RdE, RdM;
  logic        RegWriteE, RegWriteM, ResultSrcE0, PCSrcE, MemReqM, MemReadyM;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
  logic [31:0] stall_cnt, flush_cnt;
  logic        mem_err;

  int checks = 0;
  int errors = 0;

  hazard_unit #(.CNT_WIDTH(32), .MEM_TIMEOUT(255)) dut (
    .clk(clk), .rst_n(rst_n),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdE(RdE), .RdM(RdM),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .ResultSrcE0(ResultSrcE0),
    .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    Rs1D = 0; Rs2D = 0; RdE = 0; RdM = 0;
    RegWriteE = 0; RegWriteM = 0; ResultSrcE0 = 0; PCSrcE = 0;
    MemReqM = 0; MemReadyM = 1;
  endtask

  task automatic test_reset();
    checks++; if (ForwardAE !== 2'b00) begin errors++; $display("FAIL reset_fwdA: got %b expected 00", ForwardAE); end
    checks++; if (ForwardBE !== 2'b00) begin errors++; $display("FAIL reset_fwdB: got %b expected 00", ForwardBE); end
    checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt); end
    checks++; if (flush_cnt !== 32'd0) begin errors++; $display("FAIL reset_flush_cnt: got %0d expected 0", flush_cnt); end
    checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL reset_mem_err: got %b expected 0", mem_err); end
    checks++; if ({StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW} !== 7'b0)
      begin errors++; $display("FAIL reset_ctrl: got %b expected 0000000", {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}); end
  endtask

  task automatic test_back_to_back();
    idle(); RdE = 5; RegWriteE = 1; Rs1D = 5; #1;
    checks++; if (StallF !== 1'b0) begin errors++; $display("FAIL b2b_no_stall: got %b expected 0", StallF); end
    tick();
    checks++; if (ForwardAE !== 2'b10) begin errors++; $display("FAIL b2b_fwdA_E: got %b expected 10", ForwardAE); end
    checks++; if (ForwardBE !== 2'b00) begin errors++; $display("FAIL b2b_fwdB_none: got %b expected 00", ForwardBE); end
    idle(); RdE = 9; RegWriteE = 1; RdM = 5; RegWriteM = 1; Rs1D = 5; Rs2D = 9;
    tick();
    checks++; if (ForwardAE !== 2'b01) begin errors++; $display("FAIL b2b_fwdA_M: got %b expected 01", ForwardAE); end
    checks++; if (ForwardBE !== 2'b10) begin errors++; $display("FAIL b2b_fwdB_E: got %b expected 10", ForwardBE); end
    idle(); RdE = 6; RegWriteE = 1; RdM = 6; RegWriteM = 1; Rs1D = 6; Rs2D = 6;
    tick();
    checks++; if (ForwardAE !== 2'b10) begin errors++; $display("FAIL b2b_priority: got %b expected 10", ForwardAE); end
    idle(); RdM = 6; RegWriteM = 0; Rs1D = 6;
    tick();
    checks++; if (ForwardAE !== 2'b00) begin errors++; $display("FAIL b2b_no_write: got %b expected 00", ForwardAE); end
  endtask

  task automatic test_load_use();
    int s0;
    idle(); s0 = stall_cnt;
    ResultSrcE0 = 1; RegWriteE = 1; RdE = 7; Rs2D = 7; #1;
    checks++; if ({StallF, StallD, FlushE, StallE, FlushD} !== 5'b11100)
      begin errors++; $display("FAIL ldu_ctrl: got %b expected 11100", {StallF, StallD, FlushE, StallE, FlushD}); end
    tick();
    checks++; if (ForwardBE !== 2'b00) begin errors++; $display("FAIL ldu_bubble_sel: got %b expected 00", ForwardBE); end
    checks++; if (stall_cnt !== s0 + 1) begin errors++; $display("FAIL ldu_stall_cnt: got %0d expected %0d", stall_cnt, s0 + 1); end
    idle(); RdM = 7; RegWriteM = 1; Rs2D = 7; #1;
    checks++; if ({StallF, StallD, FlushE} !== 3'b000)
      begin errors++; $display("FAIL ldu_one_cycle: got %b expected 000", {StallF, StallD, FlushE}); end
    tick();
    checks++; if (ForwardBE !== 2'b01) begin errors++; $display("FAIL ldu_reissue_sel: got %b expected 01", ForwardBE); end
    checks++; if (stall_cnt !== s0 + 1) begin errors++; $display("FAIL ldu_stall_cnt2: got %0d expected %0d", stall_cnt, s0 + 1); end
  endtask

  task automatic test_branch_ldu();
    int f0;
    idle(); RdE = 3; RegWriteE = 1; Rs1D = 3; Rs2D = 3;
    tick();
    f0 = flush_cnt;
    idle(); PCSrcE = 1; ResultSrcE0 = 1; RegWriteE = 1; RdE = 3; Rs1D = 3; Rs2D = 3; #1;
    checks++; if ({FlushD, FlushE, StallF, StallD} !== 4'b1100)
      begin errors++; $display("FAIL br_ctrl: got %b expected 1100", {FlushD, FlushE, StallF, StallD}); end
    tick();
    checks++; if (flush_cnt !== f0 + 1) begin errors++; $display("FAIL br_flush_cnt: got %0d expected %0d", flush_cnt, f0 + 1); end
    checks++; if ({ForwardAE, ForwardBE} !== 4'b0000)
      begin errors++; $display("FAIL br_fwd_clear: got %b expected 0000", {ForwardAE, ForwardBE}); end
  endtask

  task automatic test_mem_wait();
    int s0, f0;
    idle(); RdE = 4; RegWriteE = 1; Rs1D = 4; RdM = 8; RegWriteM = 1; Rs2D = 8;
    tick();
    s0 = stall_cnt; f0 = flush_cnt;
    idle(); MemReqM = 1; MemReadyM = 0;
    for (int i = 0; i < 3; i++) begin
      PCSrcE = (i == 1); #1;
      checks++; if ({StallF, StallD, StallE, StallM, FlushW, FlushD, FlushE} !== 7'b1111100)
        begin errors++; $display("FAIL wait_ctrl[%0d]: got %b expected 1111100", i, {StallF, StallD, StallE, StallM, FlushW, FlushD, FlushE}); end
      tick();
      checks++; if ({ForwardAE, ForwardBE} !== 4'b1001)
        begin errors++; $display("FAIL wait_fwd_hold[%0d]: got %b expected 1001", i, {ForwardAE, ForwardBE}); end
    end
    PCSrcE = 0; MemReadyM = 1; #1;
    checks++; if ({StallF, StallM, FlushW} !== 3'b000)
      begin errors++; $display("FAIL wait_release: got %b expected 000", {StallF, StallM, FlushW}); end
    checks++; if (stall_cnt !== s0 + 3) begin errors++; $display("FAIL wait_stall_cnt: got %0d expected %0d", stall_cnt, s0 + 3); end
    checks++; if (flush_cnt !== f0) begin errors++; $display("FAIL wait_flush_cnt: got %0d expected %0d", flush_cnt, f0); end
    tick();
    checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL wait_mem_err: got %b expected 0", mem_err); end
    idle(); tick();
  endtask

  task automatic test_timeout();
    idle(); MemReqM = 1; MemReadyM = 0;
    repeat (254) tick();
    checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL to_early: got %b expected 0", mem_err); end
    tick();
    checks++; if (mem_err !== 1'b1) begin errors++; $display("FAIL to_set: got %b expected 1", mem_err); end
    repeat (3) tick();
    MemReadyM = 1;
    repeat (2) tick();
    checks++; if (mem_err !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b expected 1", mem_err); end
    idle(); #2;
    rst_n = 1'b0; #1;
    checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL to_async_clr: got %b expected 0", mem_err); end
    checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL to_async_cnt: got %0d expected 0", stall_cnt); end
    #2; rst_n = 1'b1;
    tick();
    MemReqM = 1; MemReadyM = 0;
    repeat (254) tick();
    checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL to_restart: got %b expected 0", mem_err); end
    idle(); tick();
  endtask

  task automatic test_x0();
    idle(); RdE = 0; RegWriteE = 1; ResultSrcE0 = 1; RdM = 0; RegWriteM = 1; #1;
    checks++; if ({StallF, StallD, FlushE} !== 3'b000)
      begin errors++; $display("FAIL x0_no_stall: got %b expected 000", {StallF, StallD, FlushE}); end
    tick();
    checks++; if ({ForwardAE, ForwardBE} !== 4'b0000)
      begin errors++; $display("FAIL x0_no_fwd: got %b expected 0000", {ForwardAE, ForwardBE}); end
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    #23;
    test_reset();
    rst_n = 1'b1;
    tick();
    test_reset();
    test_back_to_back();
    test_load_use();
    test_branch_ldu();
    test_mem_wait();
    test_x0();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
